lut_sweeper: RTL and testbench

LUT_SWEEPER -- requirements
Module: lut_sweeper

---
 rtl/lut_sweeper.sv | 79 +++++++
 tb/tb_lut_sweeper.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/lut_sweeper.sv
// lut_sweeper: serially loaded truth table with direct lookup and a handshaked full-table sweep.
module lut_sweeper #(
  parameter int IN_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  output logic            cfg_loaded,
  input  logic [IN_W-1:0] sel,
  output logic            out,
  input  logic            start,
  output logic            sweep_valid,
  input  logic            sweep_ready,
  output logic [IN_W-1:0] sweep_idx,
  output logic            sweep_out,
  output logic [IN_W:0]   ones_count,
  output logic            done
);
  typedef enum logic [1:0] {IDLE, LOAD, SWEEP, DONE} state_t;
  localparam int D = 2**IN_W;
  state_t state_q, state_d;
  logic [D-1:0] tbl_q;
  logic [IN_W-1:0] cnt_q, idx_q, widx;
  logic [IN_W:0] ones_q;
  logic loaded_q, out_q, acc, go, beat;
  assign cfg_ready = state_q == IDLE || state_q == LOAD;
  assign go = state_q == IDLE && start && loaded_q;
  // a granted start steals the cycle from a concurrent config bit
  assign acc = cfg_valid && cfg_ready && !go;
  assign sweep_valid = state_q == SWEEP;
  assign beat = sweep_valid && sweep_ready;
  assign widx = state_q == IDLE ? '0 : cnt_q;
  assign sweep_idx = idx_q;
  assign sweep_out = sweep_valid & tbl_q[idx_q];
  assign ones_count = ones_q;
  assign cfg_loaded = loaded_q;
  assign out = out_q;
  assign done = state_q == DONE;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = go ? SWEEP : acc ? LOAD : IDLE;
      LOAD:    state_d = acc && &cnt_q ? IDLE : LOAD;
      SWEEP:   state_d = beat && &idx_q ? DONE : SWEEP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tbl_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      ones_q <= '0;
      loaded_q <= 1'b0;
      out_q <= 1'b0;
    end else begin
      out_q <= tbl_q[sel];
      if (acc) begin
        tbl_q[widx] <= cfg_bit;
        cnt_q <= widx + IN_W'(1);
        loaded_q <= state_q == LOAD && &cnt_q;
      end
      if (go) begin
        ones_q <= '0;
        idx_q <= '0;
      end
      // idx wraps to 0 on the last beat, keeping it 0 outside SWEEP
      if (beat) begin
        ones_q <= ones_q + {{IN_W{1'b0}}, sweep_out};
        idx_q <= idx_q + IN_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_lut_sweeper.sv
// tb_lut_sweeper: scoreboard bench for load, lookup, sweep, backpressure and reset behaviour.
module tb_lut_sweeper;
  logic clk = 0, reset = 1, cfg_valid = 0, cfg_bit = 0, start = 0, sweep_ready = 1;
  logic [3:0] sel = 0;
  logic cfg_ready, cfg_loaded, out, sweep_valid, sweep_out, done;
  logic [3:0] sweep_idx;
  logic [4:0] ones_count;
  int checks = 0, errors = 0;
  int exp_q[$];
  bit mdl[16];

  lut_sweeper #(.IN_W(4)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_ready(cfg_ready), .cfg_loaded(cfg_loaded), .sel(sel), .out(out),
    .start(start), .sweep_valid(sweep_valid), .sweep_ready(sweep_ready),
    .sweep_idx(sweep_idx), .sweep_out(sweep_out), .ones_count(ones_count), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick;
      chk({tag, "_sv"}, sweep_valid, 0);
      chk({tag, "_done"}, done, 0);
    end
  endtask

  task automatic load(input logic [15:0] v, input bit sel3, input bit mid_start);
    for (int i = 0; i < 16; i++) begin
      cfg_valid = 1;
      cfg_bit = v[i];
      start = mid_start && i == 7;
      if (sel3) begin
        sel = 3;
        exp_q.push_back(i >= 4 ? int'(v[3]) : int'(mdl[3]));
      end
      tick;
      if (sel3) chk("reload_out", out, exp_q.pop_front());
      chk("load_sv", sweep_valid, 0);
      if (i == 14) chk("loaded_early", cfg_loaded, 0);
    end
    cfg_valid = 0;
    start = 0;
    for (int i = 0; i < 16; i++) mdl[i] = v[i];
    chk("loaded", cfg_loaded, 1);
    tick;
    chk("ready_after_load", cfg_ready, 1);
  endtask

  task automatic run_sweep(input int st_idx, input int st_n, input int exp_ones);
    int acc = 0, stalls = st_n, e;
    bit fin = 0;
    start = 1;
    tick;
    start = 0;
    cfg_valid = 0;
    chk("sv_start", sweep_valid, 1);
    chk("ones_clr", ones_count, 0);
    chk("cfg_ready_sweep", cfg_ready, 0);
    for (int i = 0; i < 16; i++) exp_q.push_back(i * 2 + int'(mdl[i]));
    for (int c = 0; c < 200 && !fin; c++) begin
      if (!sweep_valid) fin = 1;
      else if (int'(sweep_idx) == st_idx && stalls > 0) begin
        sweep_ready = 0;
        tick;
        chk("stall_idx", sweep_idx, st_idx);
        chk("stall_out", sweep_out, int'(mdl[st_idx]));
        chk("stall_ones", ones_count, acc);
        stalls--;
      end else begin
        sweep_ready = 1;
        e = exp_q.size() > 0 ? exp_q.pop_front() : -1;
        chk("beat_idx", sweep_idx, e >> 1);
        chk("beat_out", sweep_out, e & 1);
        chk("ones_run", ones_count, acc);
        chk("done_lo", done, 0);
        acc += e & 1;
        tick;
      end
    end
    chk("sweep_fin", fin, 1);
    chk("done_hi", done, 1);
    chk("ones_end", ones_count, exp_ones);
    chk("q_empty", exp_q.size(), 0);
    chk("idx_zero", sweep_idx, 0);
    chk("sout_zero", sweep_out, 0);
    tick;
    chk("done_pulse", done, 0);
    chk("ones_hold", ones_count, exp_ones);
    chk("ready_idle", cfg_ready, 1);
    sweep_ready = 1;
  endtask

  initial begin
    #12;
    chk("rst_out", out, 0);
    chk("rst_sv", sweep_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_ones", ones_count, 0);
    chk("rst_loaded", cfg_loaded, 0);
    chk("rst_idx", sweep_idx, 0);
    reset = 0;
    tick;
    chk("rst_ready", cfg_ready, 1);
    start = 1;
    tick;
    start = 0;
    idle_quiet("start_noload", 4);
    load(16'h8DC5, 0, 1);
    idle_quiet("start_midload", 2);
    for (int s = 0; s < 16; s++) begin
      sel = 4'(s);
      exp_q.push_back(int'(mdl[s]));
      tick;
      chk("sel_out", out, exp_q.pop_front());
    end
    run_sweep(-1, 0, 8);
    run_sweep(5, 3, 8);
    sel = 0;
    start = 1;
    tick;
    start = 0;
    for (int c = 0; c < 40 && sweep_idx != 9; c++) tick;
    chk("at_idx9", sweep_idx, 9);
    chk("pre_rst_out", out, 1);
    reset = 1;
    #1;
    chk("arst_out", out, 0);
    chk("arst_sv", sweep_valid, 0);
    chk("arst_idx", sweep_idx, 0);
    chk("arst_sout", sweep_out, 0);
    chk("arst_ones", ones_count, 0);
    chk("arst_loaded", cfg_loaded, 0);
    chk("arst_done", done, 0);
    #2;
    reset = 0;
    for (int i = 0; i < 16; i++) mdl[i] = 0;
    start = 1;
    tick;
    start = 0;
    idle_quiet("start_after_rst", 4);
    load(16'hFFFF, 1, 0);
    cfg_valid = 1;
    cfg_bit = 0;
    run_sweep(-1, 0, 16);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
